gf2_poly_divider: RTL



---
 rtl/gf2_poly_divider.sv | 130 +++++++++++++
 1 files changed

// File: rtl/gf2_poly_divider.sv
// gf2_poly_divider
//   Bit-serial carry-less (GF(2)) polynomial long divider. Consumes the latched
//   dividend MSB first, one bit per clock, and produces
//   dividend = quotient*divisor XOR remainder, with deg(remainder) < deg(divisor).
//
// Ports
//   clk        clock
//   rst        synchronous reset, active high
//   start      request, accepted only in IDLE when no done pulse is showing
//   dividend   NDVD-bit dividend, bit i = coefficient of x^i, latched on accept
//   divisor    NDVS-bit divisor, latched on accept
//   busy       high from the accept edge until the result edge
//   done       one-cycle pulse; quotient/remainder/err valid from then on
//   err        divisor was zero; held until the next accept
//   quotient   NDVD-bit quotient
//   remainder  NDVS-bit remainder
module gf2_poly_divider #(
  parameter int NDVD = 448,
  parameter int NDVS = 224
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NDVD-1:0] dividend,
  input  logic [NDVS-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [NDVD-1:0] quotient,
  output logic [NDVS-1:0] remainder
);

  localparam int DW = (NDVS > 1) ? $clog2(NDVS) : 1;
  localparam int KW = (NDVD > 1) ? $clog2(NDVD) : 1;

  typedef enum logic [1:0] {IDLE, DEG, RUN, FIN} state_t;

  state_t          state;
  logic [NDVD-1:0] dvd_q;
  logic [NDVS-1:0] dvs_q;
  logic [NDVD-1:0] q_q;
  logic [NDVS-1:0] r_q;
  logic [DW-1:0]   deg;
  logic [KW-1:0]   k;

  logic [DW-1:0]   deg_c;
  logic [NDVS:0]   t;
  logic            qbit;
  logic [NDVS-1:0] r_next;

  // Priority encoder: the last (highest) set bit wins.
  always_comb begin
    deg_c = '0;
    for (int i = 0; i < NDVS; i++)
      if (dvs_q[i]) deg_c = DW'(i);
  end

  // One long-division step. R is always below x^deg, so t fits in NDVS+1 bits
  // and XOR with the divisor clears bit deg; truncation drops only zeros.
  always_comb begin
    t      = {r_q, dvd_q[k]};
    qbit   = t[deg];
    r_next = qbit ? (t[NDVS-1:0] ^ dvs_q) : t[NDVS-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      deg       <= '0;
      k         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The cycle showing done is a non-accepting cycle.
          if (start && !done) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            q_q   <= '0;
            r_q   <= '0;
            deg   <= '0;
            k     <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= DEG;
          end
        end
        DEG: begin
          deg <= deg_c;
          if (dvs_q == '0) begin
            err       <= 1'b1;
            quotient  <= '0;
            remainder <= '0;
            state     <= FIN;
          end else begin
            err   <= 1'b0;
            k     <= KW'(NDVD - 1);
            state <= RUN;
          end
        end
        RUN: begin
          r_q <= r_next;
          q_q <= {q_q[NDVD-2:0], qbit};
          if (k == '0) state <= FIN;
          else         k     <= k - 1'b1;
        end
        FIN: begin
          if (!err) begin
            quotient  <= q_q;
            remainder <= r_q;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
